// File: rtl/spi_pkg.sv
// spi_pkg -- shared constants for the SPI master.
//   FSM state encodings used by spi_master_multi, and the sck edge-type
//   constants produced by spi_clk_gen (edges are numbered from 1, so the
//   first edge of a word is an odd edge).
package spi_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LEAD  = 2'd1;
   localparam state_t ST_XFER  = 2'd2;
   localparam state_t ST_TRAIL = 2'd3;

   localparam logic EDGE_ODD  = 1'b1;
   localparam logic EDGE_EVEN = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen -- half-period divider for the SPI master.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   clear the divider and re-arm the edge parity (new word)
//   run      in   divider counts while high
//   edge_en  in   the current tick produces an sck edge
//   div      in   half-period minus one, in clk cycles
//   tick     out  last cycle of the current half-period
//   edge_odd out  type of the next sck edge (EDGE_ODD / EDGE_EVEN)
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             run,
   input  logic             edge_en,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             edge_odd
);

   logic [DIV_W-1:0] cnt;

   // The compare happens before the increment, so div = all-ones simply
   // lets cnt roll over to zero on the tick.
   assign tick = run && (cnt == div);

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt      <= '0;
         edge_odd <= EDGE_ODD;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick && edge_en)
            edge_odd <= ~edge_odd;
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi -- SPI master with multiple slave selects.
//   clk, rst        system clock, synchronous active-high reset
//   cpol, cpha      SPI mode (latched per word)
//   lsb_first       bit order (latched per word)
//   clk_div         sck half-period = clk_div+1 clk cycles (latched per word)
//   ss_sel          slave index; out-of-range selects no line
//   tx_data/valid   word request, accepted when tx_valid && tx_ready
//   tx_ready        request can be accepted this cycle
//   rx_data/valid   received word, rx_valid pulses one cycle per word
//   busy            transfer in progress
//   sck, mosi, miso SPI bus
//   ssn             active-low slave selects
// Optional feature: define SPI_MASTER_MULTI_BURST_EN to chain words to the
// same slave without releasing ssn (the next word is taken in the last TRAIL
// cycle and LEAD is skipped).
module spi_master_multi
   import spi_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int NUM_SS = 4,
   parameter  int DIV_W  = 8,
   localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [SS_W-1:0]   ss_sel,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ssn
);

   localparam int EC_W = $clog2(2*DATA_W + 1);
   localparam logic [EC_W-1:0] EDGES     = EC_W'(2*DATA_W);
   localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W - 1);

   function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? (d >> 1) : (d << 1);
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic lsb,
                                                  input logic b);
      return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
   endfunction

   function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_W-1:0] s);
      logic [NUM_SS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (32'(s) == 32'(i)) m[i] = 1'b0;
      return m;
   endfunction

   state_t            state;
   logic              cpha_l, lsb_l;
   logic [DIV_W-1:0]  div_l;
   logic [DATA_W-1:0] tx_sh, rx_sh;
   logic [EC_W-1:0]   edge_cnt;          // sck edges already generated
   logic              sck_q, mosi_q;
   logic              tick, edge_odd;
   logic              accept, burst_ok, do_edge, shift_ev, sample_ev;

`ifdef SPI_MASTER_MULTI_BURST_EN
   logic [SS_W-1:0]   ss_l;
   // Ready in the last TRAIL cycle only for the same slave, so a handshake
   // there always means the word is really taken.
   assign burst_ok = (state == ST_TRAIL) && tick && (ss_sel == ss_l);
`else
   assign burst_ok = 1'b0;
`endif

   assign tx_ready = !rst && ((state == ST_IDLE) || burst_ok);
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state != ST_IDLE);

   // Edge 1 is produced at the end of LEAD; XFER spends one more half-period
   // after edge 2*DATA_W before moving to TRAIL.
   assign do_edge   = tick && ((state == ST_LEAD) ||
                               ((state == ST_XFER) && (edge_cnt != EDGES)));
   assign shift_ev  = do_edge && (cpha_l ? ((edge_odd == EDGE_ODD)  && (edge_cnt != '0))
                                         : ((edge_odd == EDGE_EVEN) && (edge_cnt != LAST_EDGE)));
   assign sample_ev = do_edge && (edge_odd == (cpha_l ? EDGE_EVEN : EDGE_ODD));

   // sck_q captures cpol at acceptance, so a later cpol change only shows in IDLE.
   assign sck  = (state == ST_IDLE) ? (cpol && !rst) : sck_q;
   assign mosi = (state == ST_IDLE) ? 1'b0 : mosi_q;

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .restart  (accept),
      .run      (busy),
      .edge_en  (do_edge),
      .div      (div_l),
      .tick     (tick),
      .edge_odd (edge_odd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ssn      <= '1;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         edge_cnt <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (accept) begin
            // A burst hand-over also completes the word still in rx_sh.
            if (state == ST_TRAIL) begin
               rx_data  <= rx_sh;
               rx_valid <= 1'b1;
            end
            state    <= (state == ST_TRAIL) ? ST_XFER : ST_LEAD;
            ssn      <= sel_mask(ss_sel);
            sck_q    <= cpol;
            mosi_q   <= first_bit(tx_data, lsb_first);
            tx_sh    <= tx_data;
            cpha_l   <= cpha;
            lsb_l    <= lsb_first;
            div_l    <= clk_div;
            edge_cnt <= '0;
`ifdef SPI_MASTER_MULTI_BURST_EN
            ss_l     <= ss_sel;
`endif
         end else begin
            case (state)
               ST_LEAD, ST_XFER: begin
                  if (do_edge) begin
                     sck_q    <= ~sck_q;
                     edge_cnt <= edge_cnt + 1'b1;
                     state    <= ST_XFER;
                  end else if (tick) begin
                     state <= ST_TRAIL;
                  end
               end
               ST_TRAIL: begin
                  if (tick) begin
                     state    <= ST_IDLE;
                     ssn      <= '1;
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
            if (shift_ev) begin
               tx_sh  <= shift_out(tx_sh, lsb_l);
               mosi_q <= first_bit(shift_out(tx_sh, lsb_l), lsb_l);
            end
            if (sample_ev)
               rx_sh <= shift_in(rx_sh, lsb_l, miso);
         end
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi -- directed self-checking bench for spi_master_multi.
//   Two instances share stimulus: dut (NUM_SS=4) and dut5 (NUM_SS=5, so that
//   an out-of-range slave index is representable). miso is looped back from
//   each instance's own mosi unless forced to a constant.
//   Expectations adapt to SPI_MASTER_MULTI_BURST_EN when it is defined.
module tb_spi_master_multi;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic [7:0] clk_div = 8'd0;
   logic [2:0] ss_sel3 = 3'd0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_valid = 1'b0;
   logic       miso_force = 1'b0, miso_val = 1'b0;

   logic       tx_ready, rx_valid, busy, sck, mosi, miso;
   logic [7:0] rx_data;
   logic [3:0] ssn;
   logic       tx_ready5, rx_valid5, busy5, sck5, mosi5, miso5;
   logic [7:0] rx_data5;
   logic [4:0] ssn5;

   assign miso  = miso_force ? miso_val : mosi;
   assign miso5 = miso_force ? miso_val : mosi5;

   always #5 clk = ~clk;

   spi_master_multi #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .ss_sel(ss_sel3[1:0]), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .sck(sck), .mosi(mosi), .miso(miso), .ssn(ssn)
   );

   spi_master_multi #(.DATA_W(8), .NUM_SS(5), .DIV_W(8)) dut5 (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .ss_sel(ss_sel3), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready5), .rx_data(rx_data5), .rx_valid(rx_valid5), .busy(busy5),
      .sck(sck5), .mosi(mosi5), .miso(miso5), .ssn(ssn5)
   );

   int vectors = 0, miscompares = 0;

   // per-transfer observations
   int         toggles, first_edge, gap_bad, ssn_low, rxv_cnt, last_edge_c;
   logic [7:0] mosi_seq;
   logic [3:0] ssn_seen;
   logic [4:0] ssn5_and;
   logic       sck0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one word from IDLE and watch it until rx_valid (bounded).
   task automatic xfer(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                       input logic pha, input logic lsb, input logic [7:0] div, input int flip_c);
      int c, h;
      logic prev;
      h = int'(div) + 1;
      cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; ss_sel3 = sel;
      tx_data = d; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      toggles = 0; first_edge = -1; gap_bad = 0; ssn_low = 0; rxv_cnt = 0; last_edge_c = 0;
      mosi_seq = 8'h00; ssn_seen = ssn; ssn5_and = ssn5; sck0 = sck;
      prev = sck; c = 0;
      if (ssn != 4'hF) ssn_low++;
      while (rxv_cnt == 0 && c < 4000) begin
         step(); c++;
         if (c == flip_c) cpol = ~cpol;
         if (ssn != 4'hF) ssn_low++;
         ssn5_and = ssn5_and & ssn5;
         if (rx_valid) rxv_cnt++;
         if (busy && sck != prev) begin
            toggles++;
            if (toggles == 1) first_edge = c;
            else if (c - last_edge_c != h) gap_bad++;
            last_edge_c = c;
            if ((toggles % 2 == 1) != pha) mosi_seq = {mosi_seq[6:0], mosi};
         end
         prev = sck;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (rx_valid) rxv_cnt++;
      end
   endtask

   initial begin
      int c, acc, rxv, ssn_hi;
      logic prev, hs;
      logic [7:0] rx1, rx2;

      // ---- reset state
      step(); step();
      chk("rst_ssn", ssn, 4'hF);
      chk("rst_ssn5", ssn5, 5'h1F);
      chk("rst_sck", sck, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      rst = 1'b0;
      step();
      chk("post_rst_tx_ready", tx_ready, 1'b1);

      // ---- mode 0, div 1, 0xA5 loopback, slave 0
      xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 0);
      chk("m0_sck_lead", sck0, 1'b0);
      chk("m0_toggles", toggles, 16);
      chk("m0_first_edge", first_edge, 2);
      chk("m0_gap_bad", gap_bad, 0);
      chk("m0_ssn_seen", ssn_seen, 4'b1110);
      chk("m0_ssn_low", ssn_low, 36);
      chk("m0_mosi_seq", mosi_seq, 8'hA5);
      chk("m0_rx_data", rx_data, 8'hA5);
      chk("m0_rxv_pulses", rxv_cnt, 1);

      // ---- cpha=1, div 2, slave 2
      xfer(8'h5A, 3'd2, 1'b0, 1'b1, 1'b0, 8'd2, 0);
      chk("ss2_ssn_seen", ssn_seen, 4'b1011);
      chk("ss2_ssn_low", ssn_low, 54);
      chk("ss2_first_edge", first_edge, 3);
      chk("ss2_gap_bad", gap_bad, 0);
      chk("ss2_mosi_seq", mosi_seq, 8'h5A);
      chk("ss2_rx_data", rx_data, 8'h5A);
      chk("ss2_ssn5", ssn5_and, 5'h1B);

      // ---- out-of-range slave on the 5-slave instance, div 0
      xfer(8'hE1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 0);
      chk("ss5_ssn5", ssn5_and, 5'h1F);
      chk("ss5_rx5", rx_data5, 8'hE1);
      chk("ss5_ssn_low", ssn_low, 18);
      chk("ss5_ssn_seen", ssn_seen, 4'b1101);
      xfer(8'h0F, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0, 0);
      chk("ss4_ssn5", ssn5_and, 5'h0F);

      // ---- cpol flipped mid-transfer
      xfer(8'h69, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1, 5);
      chk("flip_toggles", toggles, 16);
      chk("flip_gap_bad", gap_bad, 0);
      chk("flip_rx_data", rx_data, 8'h69);
      chk("flip_idle_sck", sck, 1'b1);

      // ---- mode 3, LSB first, 0x3C, miso tied 1, div 0
      miso_force = 1'b1; miso_val = 1'b1;
      xfer(8'h3C, 3'd1, 1'b1, 1'b1, 1'b1, 8'd0, 0);
      miso_force = 1'b0;
      chk("m3_sck_lead", sck0, 1'b1);
      chk("m3_first_edge", first_edge, 1);
      chk("m3_toggles", toggles, 16);
      chk("m3_mosi_seq", mosi_seq, 8'h3C);
      chk("m3_rx_data", rx_data, 8'hFF);
      chk("m3_ssn_low", ssn_low, 18);
      chk("m3_idle_sck", sck, 1'b1);

      // ---- reset after sck edge 7
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; ss_sel3 = 3'd1;
      tx_data = 8'hC3; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      toggles = 0; c = 0; prev = sck;
      while (toggles < 7 && c < 200) begin
         step(); c++;
         if (busy && sck != prev) toggles++;
         prev = sck;
      end
      chk("abort_reach_e7", toggles, 7);
      rst = 1'b1;
      step();
      chk("abort_ssn", ssn, 4'hF);
      chk("abort_sck", sck, 1'b0);
      chk("abort_rx_valid", rx_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_tx_ready", tx_ready, 1'b0);
      rst = 1'b0;
      rxv_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rx_valid) rxv_cnt++;
      end
      chk("abort_no_rxv", rxv_cnt, 0);
      chk("abort_rx_data", rx_data, 8'h00);
      xfer(8'h96, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1, 0);
      chk("after_abort_rx", rx_data, 8'h96);
      chk("after_abort_pulses", rxv_cnt, 1);

      // ---- two back-to-back words to the same slave
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; ss_sel3 = 3'd3;
      tx_data = 8'h12; tx_valid = 1'b1;
      acc = 0; rxv = 0; ssn_hi = 0; c = 0; rx1 = 8'h00; rx2 = 8'h00;
      while (rxv < 2 && c < 500) begin
         hs = tx_valid && tx_ready;
         step(); c++;
         if (hs) begin
            acc++;
            if (acc == 1) tx_data = 8'h34;
            else tx_valid = 1'b0;
         end
         if (rx_valid) begin
            rxv++;
            if (rxv == 1) rx1 = rx_data;
            else rx2 = rx_data;
         end
         if (acc >= 1 && rxv < 2 && ssn == 4'hF) ssn_hi++;
      end
      tx_valid = 1'b0;
      chk("b2b_pulses", rxv, 2);
      chk("b2b_rx1", rx1, 8'h12);
      chk("b2b_rx2", rx2, 8'h34);
`ifdef SPI_MASTER_MULTI_BURST_EN
      chk("b2b_ssn_gap", ssn_hi, 0);
`else
      chk("b2b_ssn_gap", (ssn_hi > 0), 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8, meaning bits per word (legal 4..32).
REQ-002 Parameter NUM_SS, default 4, meaning number of slave-select lines (legal 1..16).
REQ-003 Parameter DIV_W, default 8, meaning width of the clock-divider field.
REQ-004 Ports, one per line:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- cpol  in  1  SCK idle level
- cpha  in  1  0: sample odd edges / shift even; 1: shift odd / sample even
- lsb_first  in  1  bit order, 1 = LSB first
- clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles
- ss_sel  in  $clog2(NUM_SS) (min 1)  slave index for the word
- tx_data  in  DATA_W  word to send
- tx_valid  in  1  request transfer
- tx_ready  out  1  high only in IDLE
- rx_data  out  DATA_W  last received word, held until next completion
- rx_valid  out  1  one-cycle pulse on word completion
- busy  out  1  high in any state other than IDLE
- sck, mosi  out  1  SPI clock / data out
- miso  in  1  SPI data in
- ssn  out  NUM_SS  active-low selects, at most one low

Function
REQ-005 FSM states IDLE, LEAD, XFER, TRAIL; H = clk_div+1 clk cycles.
REQ-006 Transfer is accepted on the cycle tx_valid && tx_ready; cpol, cpha, lsb_first, clk_div, ss_sel and tx_data are latched then and ignored until IDLE returns.
REQ-007 Next cycle after acceptance: ssn[ss_sel] = 0, state LEAD for H cycles, sck = cpol, mosi = first data bit.
REQ-008 XFER generates exactly 2*DATA_W sck toggles, H cycles apart, first toggle H cycles after LEAD entry.
REQ-009 CPHA=0: miso sampled on odd edges; mosi updated on even edges except the last.
REQ-010 CPHA=1: mosi updated on odd edges (first bit presented on edge 1); miso sampled on even edges.
REQ-011 Bit order: lsb_first=0 sends/receives MSB first; lsb_first=1 LSB first; rx_data assembled in same order as sent.
REQ-012 TRAIL lasts H cycles with sck = cpol; then ssn all-ones, rx_data updated, rx_valid pulses one cycle, state IDLE.
REQ-013 An out-of-range ss_sel (>= NUM_SS) is accepted but asserts no ssn line; timing unchanged.
REQ-014 mosi = 0 and sck = cpol (live input) in IDLE.
REQ-015 Divider counter width DIV_W; clk_div = 0 gives sck = clk/2; clk_div all-ones gives no wrap error.

Reset
REQ-016 On rst: state IDLE, ssn all-ones, sck = 0, mosi = 0, rx_data = 0, rx_valid = 0, busy = 0, tx_ready = 0 during rst, 1 the cycle after.
REQ-017 rst mid-transfer aborts within one cycle: ssn deasserted, no rx_valid pulse.

Configuration
REQ-018 Macro SPI_MASTER_MULTI_BURST_EN: when defined, if tx_valid is high with the same ss_sel in the last TRAIL cycle, the next word is accepted, ssn stays low, LEAD is skipped and XFER restarts after one H; rx_valid still pulses per word; tx_ready is also high in that last TRAIL cycle.
REQ-019 Without SPI_MASTER_MULTI_BURST_EN, ssn always deasserts for at least one cycle between words and tx_ready is high only in IDLE.

Structure
REQ-020 Shared package spi_pkg holds the FSM state enum and edge-type constants.
REQ-021 One sub-module spi_clk_gen (divider counter, H-tick and edge-parity output); the shift register and FSM stay in spi_master_multi.

Verification
REQ-022 DATA_W=8, mode 0, clk_div=1, tx 0xA5, miso loopback -> 16 sck edges 2 clk apart, rx_data 0xA5, rx_valid single pulse.
REQ-023 Mode 3 (cpol=1, cpha=1), lsb_first=1, tx 0x3C, miso tied 1 -> sck idles high, mosi order 0,0,1,1,1,1,0,0, rx_data 0xFF.
REQ-024 NUM_SS=4, ss_sel=2 -> only ssn[2] low for LEAD+XFER+TRAIL = (2+16)*H clk cycles; ss_sel=5 -> ssn stays 4'hF.
REQ-025 rst asserted at edge 7 -> next cycle ssn all-ones, sck 0, no rx_valid; next word completes normally.
REQ-026 cpol toggled mid-transfer -> waveform unaffected; change takes effect at next acceptance.
REQ-027 BURST_EN defined, two back-to-back words 0x12, 0x34 same ss_sel -> ssn continuously low, two rx_valid pulses; undefined -> ssn high between words.
